// File: rtl/ls_pkg.sv
// Shared types and constants for the two-slot load/store unit.
package ls_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int REG_W  = 5;

  localparam logic [6:0] OP_LOAD  = 7'h20;
  localparam logic [6:0] OP_STORE = 7'h21;

  typedef enum logic [1:0] {IDLE, ACC_A, ACC_B} state_e;

  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic              is_wb;
    logic [REG_W-1:0]  wb_addr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Loads present zero write data.
  function automatic mem_req_t mk_req(input slot_t s);
    mem_req_t r;
    r.req   = 1'b1;
    r.we    = !s.is_load;
    r.addr  = s.addr;
    r.wdata = s.is_load ? '0 : s.data;
    return r;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// Single-outstanding memory request/ack bus between the LSU and memory.
interface load_store_unit_if;
  import ls_pkg::*;
  logic              memReq_o;
  logic              memWe_o;
  logic [ADDR_W-1:0] memAddr_o;
  logic [DATA_W-1:0] memWdata_o;
  logic              memAck_i;
  logic [DATA_W-1:0] memRdata_i;

  modport master (output memReq_o, memWe_o, memAddr_o, memWdata_o,
                  input  memAck_i, memRdata_i);
  modport slave  (input  memReq_o, memWe_o, memAddr_o, memWdata_o,
                  output memAck_i, memRdata_i);
endinterface

// File: rtl/ls_slot.sv
// One captured issue slot; capture overwrites, clear drops only the valid bit.
module ls_slot
  import ls_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  cap_i,
  input  logic  clr_i,
  input  slot_t slot_i,
  output slot_t slot_o
);
  slot_t slot_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     slot_q       <= '0;
    else if (cap_i)  slot_q       <= slot_i;
    else if (clr_i)  slot_q.valid <= 1'b0;
  end

  assign slot_o = slot_q;
endmodule

// File: rtl/load_store_unit.sv
// Two-slot load/store unit: captures slot A/B in IDLE and issues them in order
// over a request/ack memory bus, with flush-aware writeback and completion count.
module load_store_unit
  import ls_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              lsEnableA_i,
  input  logic              lsEnableB_i,
  input  logic              isWbLSA_i,
  input  logic              isWbLSB_i,
  input  logic [REG_W-1:0]  lsWbAddressA_i,
  input  logic [REG_W-1:0]  lsWbAddressB_i,
  input  logic [6:0]        lsOpCodeA_i,
  input  logic [6:0]        lsOpCodeB_i,
  input  logic [ADDR_W-1:0] lsPoperandA_i,
  input  logic [ADDR_W-1:0] lsPoperandB_i,
  input  logic [DATA_W-1:0] lsSoperandA_i,
  input  logic [DATA_W-1:0] lsSoperandB_i,
  input  logic              flushBack_i,
  load_store_unit_if.master mem,
  output logic              busy_o,
  output logic              wbEnable_o,
  output logic [REG_W-1:0]  wbAddress_o,
  output logic [DATA_W-1:0] wbData_o,
  output logic [15:0]       completedCount_o
);
  state_e            state_q;
  logic              flushed_q;
  mem_req_t          mreq_q;
  logic              wb_en_q;
  logic [REG_W-1:0]  wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [15:0]       cnt_q;

  slot_t in_a, in_b, slot_a, slot_b, cur;
  logic  cap, ack, flush_hit, clr_a, clr_b;

  assign in_a = '{valid: lsEnableA_i && is_mem_op(lsOpCodeA_i),
                  is_load: lsOpCodeA_i == OP_LOAD, is_wb: isWbLSA_i,
                  wb_addr: lsWbAddressA_i, addr: lsPoperandA_i, data: lsSoperandA_i};
  assign in_b = '{valid: lsEnableB_i && is_mem_op(lsOpCodeB_i),
                  is_load: lsOpCodeB_i == OP_LOAD, is_wb: isWbLSB_i,
                  wb_addr: lsWbAddressB_i, addr: lsPoperandB_i, data: lsSoperandB_i};

  // Request is always high outside IDLE, so ack is only honoured there.
  assign ack       = mem.memAck_i && (state_q != IDLE);
  assign flush_hit = flushed_q || flushBack_i;
  assign cap       = (state_q == IDLE) && !flushBack_i;
  assign clr_a     = ack && (state_q == ACC_A);
  assign clr_b     = ack && ((state_q == ACC_B) || flush_hit);
  assign cur       = (state_q == ACC_A) ? slot_a : slot_b;

  ls_slot u_slot_a (.clk_i(clock_i), .rst_ni(reset_i), .cap_i(cap), .clr_i(clr_a),
                    .slot_i(in_a), .slot_o(slot_a));
  ls_slot u_slot_b (.clk_i(clock_i), .rst_ni(reset_i), .cap_i(cap), .clr_i(clr_b),
                    .slot_i(in_b), .slot_o(slot_b));

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      flushed_q <= 1'b0;
      mreq_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      wb_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          flushed_q <= 1'b0;
          if (!flushBack_i) begin
            if (in_a.valid) begin
              state_q <= ACC_A;
              mreq_q  <= mk_req(in_a);
            end else if (in_b.valid) begin
              state_q <= ACC_B;
              mreq_q  <= mk_req(in_b);
            end
          end
        end
        ACC_A, ACC_B: begin
          if (ack) begin
            flushed_q <= 1'b0;
            if (!flush_hit) begin
              cnt_q <= cnt_q + 16'd1;
              if (cur.is_load && cur.is_wb) begin
                wb_en_q   <= 1'b1;
                wb_addr_q <= cur.wb_addr;
                wb_data_q <= mem.memRdata_i;
              end
            end
            // A flushed ack discards any pending B.
            if ((state_q == ACC_A) && slot_b.valid && !flush_hit) begin
              state_q <= ACC_B;
              mreq_q  <= mk_req(slot_b);
            end else begin
              state_q <= IDLE;
              mreq_q  <= '0;
            end
          end else if (flushBack_i) begin
            flushed_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          mreq_q  <= '0;
        end
      endcase
    end
  end

  // Slot A's request fields are issued straight from the inputs at capture.
  logic unused_slot_a;
  assign unused_slot_a = ^{slot_a.valid, slot_a.addr, slot_a.data};

  assign busy_o           = (state_q != IDLE);
  assign mem.memReq_o     = mreq_q.req;
  assign mem.memWe_o      = mreq_q.we;
  assign mem.memAddr_o    = mreq_q.addr;
  assign mem.memWdata_o   = mreq_q.wdata;
  assign wbEnable_o       = wb_en_q;
  assign wbAddress_o      = wb_addr_q;
  assign wbData_o         = wb_data_q;
  assign completedCount_o = cnt_q;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clock_i  input  1  single clock; all state updates on its rising edge.
REQ-002 reset_i  input  1  reset; asynchronous, active-low (0 = reset).
REQ-003 lsEnableA_i, lsEnableB_i  input  1 each  slot A/B holds a load-store op this cycle.
REQ-004 isWbLSA_i, isWbLSB_i  input  1 each  slot A/B result is written back.
REQ-005 lsWbAddressA_i, lsWbAddressB_i  input  5 each  destination register per slot.
REQ-006 lsOpCodeA_i, lsOpCodeB_i  input  7 each  opcode per slot.
REQ-007 lsPoperandA_i, lsPoperandB_i  input  16 each  memory address per slot.
REQ-008 lsSoperandA_i, lsSoperandB_i  input  16 each  store data per slot.
REQ-009 flushBack_i  input  1  pipeline flush.
REQ-010 memReq_o, memWe_o  output  1 each  memory request and write-enable (1 = store).
REQ-011 memAddr_o, memWdata_o  output  16 each  memory address and write data.
REQ-012 memAck_i  input  1  memory completes the presented request at this edge.
REQ-013 memRdata_i  input  16  load data, valid when memAck_i = 1.
REQ-014 busy_o  output  1  unit not IDLE; inputs are ignored while 1.
REQ-015 wbEnable_o  output  1  one-cycle register writeback pulse.
REQ-016 wbAddress_o  output  5  writeback register.
REQ-017 wbData_o  output  16  writeback data.
REQ-018 completedCount_o  output  16  count of completed, non-flushed accesses.

Function
REQ-019 Opcodes: OP_LOAD = 7'h20, OP_STORE = 7'h21; an enabled slot with any other opcode is dropped at capture.
REQ-020 States: IDLE, ACC_A, ACC_B; busy_o = (state != IDLE), combinational.
REQ-021 In IDLE with flushBack_i = 0, valid slots are captured at the edge; state moves to ACC_A if A is valid, else to ACC_B if B is valid, else stays IDLE.
REQ-022 Requests are registered: memReq_o = 1 with memWe_o, memAddr_o and memWdata_o of the active slot from the cycle after capture; memWdata_o = 0 for loads.
REQ-023 The request stays stable until an edge where memAck_i = 1; memAck_i is ignored while memReq_o = 0.
REQ-024 On ack in ACC_A with B pending: the next cycle presents B's request (back-to-back, memReq_o stays 1) and state moves to ACC_B.
REQ-025 On ack otherwise: memReq_o goes to 0 and state moves to IDLE.
REQ-026 On ack of a load with isWb = 1: at that edge, wbData_o <= memRdata_i, wbAddress_o <= slot wb address, and wbEnable_o = 1 for exactly one cycle.
REQ-027 Stores and isWb = 0 loads never pulse wbEnable_o.
REQ-028 completedCount_o increments by 1 on each non-flushed ack and wraps from 16'hFFFF to 16'h0000.
REQ-029 Flush in IDLE: nothing is captured; flush takes priority over simultaneous enables.
REQ-030 Flush in ACC_A/ACC_B: the outstanding request is held until ack and is not aborted.
REQ-031 Flush in ACC_A/ACC_B: that ack produces no writeback and no count increment, pending B is discarded, and the unit returns to IDLE.
REQ-032 A flush seen in any cycle of an outstanding access marks it flushed until its ack.
REQ-033 Best-case latency: capture edge -> request next cycle -> ack at that cycle's edge -> wbEnable_o high in the following cycle (2 cycles from capture).

Reset
REQ-034 While reset_i = 0: state = IDLE, slots invalid, flushed mark cleared.
REQ-035 While reset_i = 0: memReq_o, memWe_o, memAddr_o, memWdata_o, wbEnable_o, wbAddress_o, wbData_o and completedCount_o are all 0.
REQ-036 Reset asserted mid-access abandons the access immediately; on release the unit does not re-issue it.

Structure
REQ-037 Package ls_pkg holds OP_LOAD, OP_STORE, the state enumeration and the address/data widths (16) and register-address width (5).
REQ-038 One sub-module, ls_slot, holds a captured slot (valid, isLoad, isWb, wbAddress, address, data) with capture and clear controls; it is instantiated twice.

Verification
REQ-039 Single load: A = OP_LOAD, addr 16'h0040, wb r5, isWb = 1; ack in the first request cycle with rdata 16'h1234 -> memReq_o high 1 cycle, wbEnable_o pulse with r5/16'h1234 two cycles after capture, count = 1.
REQ-040 Dual slots: A = store to 16'h0010 with data 16'hBEEF, B = load from 16'h0020 to r3; ack held off 3 cycles each -> store request stable for 4 cycles, B request follows back-to-back, one wb pulse (r3), busy_o low after the second ack.
REQ-041 Flush mid-access: A = load, B = load, flushBack_i pulsed while A is unacked -> A request held until ack, no wb pulse, B never requested, count unchanged, IDLE.
REQ-042 Flush plus enable in IDLE, and an illegal opcode 7'h05 in slot A -> no capture, busy_o stays 0, no memReq_o.
REQ-043 Wrap: preload the count to 16'hFFFF by 65535 stores, then one more store -> completedCount_o = 16'h0000.
REQ-044 Async reset: drop reset_i between clock edges during ACC_B -> all outputs 0 immediately; no request after release.
